alu_issue_unit: RTL and testbench
=================================

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/result width (only 32 supported).
REQ-002 SHALL have: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  async active-high reset.
REQ-005 in_valid  in  1; in_ready  out  1: instruction handshake.
REQ-006 instr  in  32  RV32 instruction; rs1_data, rs2_data  in  32  register operands.
REQ-007 data_1, data_2  out  32; ALU_Control_signal  out  3: operands and op code to ALU.
REQ-008 AL_Unit_out  in  32; Flag  in  1: ALU result and equality flag.
REQ-009 res_valid  out  1; res_ready  in  1: result handshake.
REQ-010 res_data  out  32; res_rd  out  5; res_we  out  1; br_taken  out  1; illegal  out  1.

Function
REQ-011 SHALL decode ALU codes: 000 add, 001 sub, 010 or, 011 xor, 100 and, 101 unsigned less-than.
REQ-012 SHALL decode opcode 0110011 (R): f3/f7 000/0000000 add, 000/0100000 sub, 110 or, 100 xor, 111 and, 011/0000000 sltu.
REQ-013 SHALL decode opcode 0010011 (I): addi, ori, xori, andi, sltiu; data_2 = sign-extended instr[31:20].
REQ-014 SHALL decode opcode 1100011 beq (f3 000)/bne (f3 001) as sub on rs1_data, rs2_data; res_we=0.
REQ-015 Any other encoding (incl. R-type with other f7, code 110 never issued) SHALL be illegal.
REQ-016 FSM states IDLE, EXEC, CAPT, DONE; in_ready=1 only in IDLE.
REQ-017 IDLE: in_valid=1 -> latch instr fields, operands, op; legal -> EXEC, illegal -> DONE.
REQ-018 EXEC and CAPT: data_1/data_2/ALU_Control_signal held stable from registers; EXEC -> CAPT unconditionally.
REQ-019 CAPT: sample AL_Unit_out and Flag at clock edge -> DONE.
REQ-020 Branch: br_taken = Flag (beq) or ~Flag (bne); 0 for non-branch; res_data = AL_Unit_out sample.
REQ-021 R/I: res_we=1, res_rd=instr[11:7]; res_we forced 0 when rd=0.
REQ-022 Illegal: illegal=1, res_we=0, br_taken=0, res_data=0; ALU inputs unchanged.
REQ-023 DONE: res_valid=1, all res_* stable until res_ready=1 -> IDLE; no new accept same cycle.
REQ-024 Latency: accept edge N -> res_valid high after edge N+3 (legal), N+1 (illegal); max throughput 1 per 4 cycles.
REQ-025 Arithmetic wraps modulo 2^32; sltu compares unsigned; no exceptions raised.

Reset
REQ-026 rst SHALL force IDLE immediately, any state, discarding in-flight instruction.
REQ-027 Reset values: data_1=0, data_2=0, ALU_Control_signal=000, res_valid=0, res_data=0, res_rd=0, res_we=0, br_taken=0, illegal=0, in_ready=1.

Structure
REQ-028 Package alu_pkg SHALL hold ALU op codes, RV opcode/funct constants, FSM state encoding.
REQ-029 Combinational sub-module alu_decoder SHALL map instr -> ALU code, immediate select, sign-extended imm, is_branch, branch polarity, illegal.

Verification (bench instantiates AL_Unit as ALU)
REQ-030 instr 0x002081B3 (add x3,x1,x2), rs1=5, rs2=7 -> ALU_Control_signal=000, res_data=12, res_rd=3, res_we=1, 3 cycles.
REQ-031 instr 0xFFF00093 (addi x1,x0,-1), rs1=0 -> data_2=0xFFFFFFFF, res_data=0xFFFFFFFF, res_rd=1.
REQ-032 instr 0x00208063 (beq x1,x2), rs1=rs2=9 -> code 001, br_taken=1, res_we=0; rs2=8 -> br_taken=0; bne 0x00209063, rs1=9, rs2=8 -> br_taken=1.
REQ-033 instr 0x00000000 -> illegal=1, res_valid next cycle, res_we=0, res_data=0.
REQ-034 res_ready=0 for 5 cycles after res_valid -> outputs stable, in_ready=0; then res_ready=1 -> IDLE, in_ready=1.
REQ-035 rst pulse in EXEC -> all outputs at reset values, no res_valid; next add completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU op codes, RV32 opcode/funct constants and issue FSM state encoding.
// Pure declarations: no latency, no backpressure.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;

  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [2:0] F3_SLTU  = 3'b011;
  localparam logic [2:0] F3_XOR   = 3'b100;
  localparam logic [2:0] F3_OR    = 3'b110;
  localparam logic [2:0] F3_AND   = 3'b111;
  localparam logic [2:0] F3_BEQ   = 3'b000;
  localparam logic [2:0] F3_BNE   = 3'b001;

  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_DONE = 2'd3
  } issue_state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational RV32 decode of the ALU subset into ALU code, operand select and branch info.
// Latency 0; no backpressure (pure function of instr).
module alu_decoder
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  alu_code,
  output logic        use_imm,
  output logic [31:0] imm,
  output logic        is_branch,
  output logic        br_inv,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] unused_fields;

  assign opcode        = instr[6:0];
  assign f3            = instr[14:12];
  assign f7            = instr[31:25];
  assign imm           = {{20{instr[31]}}, instr[31:20]};
  assign unused_fields = instr[19:15];

  always_comb begin
    alu_code  = ALU_ADD;
    use_imm   = 1'b0;
    is_branch = 1'b0;
    br_inv    = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_R: begin
        if (f7 == F7_BASE) begin
          case (f3)
            F3_ADD:  alu_code = ALU_ADD;
            F3_OR:   alu_code = ALU_OR;
            F3_XOR:  alu_code = ALU_XOR;
            F3_AND:  alu_code = ALU_AND;
            F3_SLTU: alu_code = ALU_SLTU;
            default: illegal  = 1'b1;
          endcase
        end else if (f7 == F7_ALT && f3 == F3_ADD) begin
          alu_code = ALU_SUB;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_I: begin
        use_imm = 1'b1;
        case (f3)
          F3_ADD:  alu_code = ALU_ADD;
          F3_OR:   alu_code = ALU_OR;
          F3_XOR:  alu_code = ALU_XOR;
          F3_AND:  alu_code = ALU_AND;
          F3_SLTU: alu_code = ALU_SLTU;
          default: illegal  = 1'b1;
        endcase
      end
      OPC_BR: begin
        // Branches compare by subtracting; the ALU's equality flag decides.
        alu_code  = ALU_SUB;
        is_branch = 1'b1;
        case (f3)
          F3_BEQ:  br_inv  = 1'b0;
          F3_BNE:  br_inv  = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Issues one RV32 ALU/branch instruction to an external ALU and returns its result; 3 cycles legal, 1 illegal.
// Backpressure: in_ready only in IDLE; result held in DONE until res_ready, so at most 1 instr per 4 cycles.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] data_1,
  output logic [DATA_W-1:0] data_2,
  output logic [2:0]        ALU_Control_signal,
  input  logic [DATA_W-1:0] AL_Unit_out,
  input  logic              Flag,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [4:0]        res_rd,
  output logic              res_we,
  output logic              br_taken,
  output logic              illegal
);

  issue_state_t state_q, state_d;

  logic [2:0]  dec_code;
  logic        dec_use_imm;
  logic [31:0] dec_imm;
  logic        dec_is_branch;
  logic        dec_br_inv;
  logic        dec_illegal;

  logic [4:0]  pend_rd;
  logic        pend_we;
  logic        pend_br;
  logic        pend_inv;

  alu_decoder u_dec (
    .instr     (instr),
    .alu_code  (dec_code),
    .use_imm   (dec_use_imm),
    .imm       (dec_imm),
    .is_branch (dec_is_branch),
    .br_inv    (dec_br_inv),
    .illegal   (dec_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = dec_illegal ? ST_DONE : ST_EXEC;
      end
      ST_EXEC: state_d = ST_CAPT;
      ST_CAPT: state_d = ST_DONE;
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_1             <= '0;
      data_2             <= '0;
      ALU_Control_signal <= ALU_ADD;
      res_data           <= '0;
      res_rd             <= '0;
      res_we             <= 1'b0;
      br_taken           <= 1'b0;
      illegal            <= 1'b0;
      pend_rd            <= '0;
      pend_we            <= 1'b0;
      pend_br            <= 1'b0;
      pend_inv           <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (dec_illegal) begin
              // ALU operands are left as they were; only the result side reports.
              res_data <= '0;
              res_rd   <= '0;
              res_we   <= 1'b0;
              br_taken <= 1'b0;
              illegal  <= 1'b1;
            end else begin
              data_1             <= rs1_data;
              data_2             <= dec_use_imm ? dec_imm : rs2_data;
              ALU_Control_signal <= dec_code;
              pend_rd            <= dec_is_branch ? 5'd0 : instr[11:7];
              pend_we            <= !dec_is_branch && (instr[11:7] != 5'd0);
              pend_br            <= dec_is_branch;
              pend_inv           <= dec_br_inv;
            end
          end
        end
        ST_CAPT: begin
          res_data <= AL_Unit_out;
          res_rd   <= pend_rd;
          res_we   <= pend_we;
          br_taken <= pend_br & (Flag ^ pend_inv);
          illegal  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench: behavioural ALU attached to the issue unit, hand-computed expected results.
// Checks reset values, each op class, latency, result hold under backpressure and mid-flight reset.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] data_1;
  logic [31:0] data_2;
  logic [2:0]  ALU_Control_signal;
  logic [31:0] AL_Unit_out;
  logic        Flag;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        res_we;
  logic        br_taken;
  logic        illegal;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_issue_unit #(.DATA_W(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .instr              (instr),
    .rs1_data           (rs1_data),
    .rs2_data           (rs2_data),
    .data_1             (data_1),
    .data_2             (data_2),
    .ALU_Control_signal (ALU_Control_signal),
    .AL_Unit_out        (AL_Unit_out),
    .Flag               (Flag),
    .res_valid          (res_valid),
    .res_ready          (res_ready),
    .res_data           (res_data),
    .res_rd             (res_rd),
    .res_we             (res_we),
    .br_taken           (br_taken),
    .illegal            (illegal)
  );

  // Behavioural AL_Unit: combinational result plus operand-equality flag.
  always_comb begin
    AL_Unit_out = 32'h0;
    case (ALU_Control_signal)
      3'b000:  AL_Unit_out = data_1 + data_2;
      3'b001:  AL_Unit_out = data_1 - data_2;
      3'b010:  AL_Unit_out = data_1 | data_2;
      3'b011:  AL_Unit_out = data_1 ^ data_2;
      3'b100:  AL_Unit_out = data_1 & data_2;
      3'b101:  AL_Unit_out = {31'b0, data_1 < data_2};
      default: AL_Unit_out = 32'h0;
    endcase
    Flag = (data_1 == data_2);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issue one instruction, check ALU inputs in EXEC, latency, result fields, hold, then release.
  task automatic run_op(input string tag, input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] exp_code,
                        input logic [31:0] exp_d2, input int exp_lat,
                        input logic [31:0] exp_data, input logic [4:0] exp_rd,
                        input logic exp_we, input logic exp_br, input logic exp_ill,
                        input int hold);
    int lat;
    logic [31:0] held;
    lat = 0;
    @(posedge clk); #1;
    instr = ins; rs1_data = a; rs2_data = b; in_valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        in_valid = 1'b0;
        if (!exp_ill) begin
          check({tag, ".code"}, {29'b0, ALU_Control_signal}, {29'b0, exp_code});
          check({tag, ".d2"}, data_2, exp_d2);
        end
      end
      if (res_valid) begin
        lat = c;
        break;
      end
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".data"}, res_data, exp_data);
    check({tag, ".rd"}, {27'b0, res_rd}, {27'b0, exp_rd});
    check({tag, ".we"}, {31'b0, res_we}, {31'b0, exp_we});
    check({tag, ".br"}, {31'b0, br_taken}, {31'b0, exp_br});
    check({tag, ".ill"}, {31'b0, illegal}, {31'b0, exp_ill});
    held = res_data;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, ".hold_vld"}, {31'b0, res_valid}, 32'd1);
      check({tag, ".hold_rdy"}, {31'b0, in_ready}, 32'd0);
      check({tag, ".hold_dat"}, res_data, held);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, ".rel_rdy"}, {31'b0, in_ready}, 32'd1);
    check({tag, ".rel_vld"}, {31'b0, res_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
    instr = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", {31'b0, in_ready}, 32'd1);
    check("rst.res_valid", {31'b0, res_valid}, 32'd0);
    check("rst.data_1", data_1, 32'h0);
    check("rst.data_2", data_2, 32'h0);
    check("rst.code", {29'b0, ALU_Control_signal}, 32'h0);
    check("rst.res_data", res_data, 32'h0);
    rst = 1'b0;

    //     tag      instr         rs1          rs2          code    d2           lat data         rd  we    br    ill   hold
    run_op("add",   32'h002081B3, 32'd5,       32'd7,       3'b000, 32'd7,       3, 32'd12,       3, 1'b1, 1'b0, 1'b0, 5);
    run_op("addi",  32'hFFF00093, 32'd0,       32'h55,      3'b000, 32'hFFFFFFFF,3, 32'hFFFFFFFF, 1, 1'b1, 1'b0, 1'b0, 0);
    run_op("beq_t", 32'h00208063, 32'd9,       32'd9,       3'b001, 32'd9,       3, 32'd0,        0, 1'b0, 1'b1, 1'b0, 0);
    run_op("beq_n", 32'h00208063, 32'd9,       32'd8,       3'b001, 32'd8,       3, 32'd1,        0, 1'b0, 1'b0, 1'b0, 0);
    run_op("bne_t", 32'h00209063, 32'd9,       32'd8,       3'b001, 32'd8,       3, 32'd1,        0, 1'b0, 1'b1, 1'b0, 0);
    run_op("ill0",  32'h00000000, 32'd1,       32'd2,       3'b000, 32'd0,       1, 32'd0,        0, 1'b0, 1'b0, 1'b1, 2);
    check("ill0.keep_code", {29'b0, ALU_Control_signal}, 32'd1);
    check("ill0.keep_d1", data_1, 32'd9);
    check("ill0.keep_d2", data_2, 32'd8);
    run_op("sub",   32'h407302B3, 32'd3,       32'd5,       3'b001, 32'd5,       3, 32'hFFFFFFFE, 5, 1'b1, 1'b0, 1'b0, 0);
    run_op("sltu",  32'h0020B233, 32'd1,       32'hFFFFFFFF,3'b101, 32'hFFFFFFFF,3, 32'd1,        4, 1'b1, 1'b0, 1'b0, 0);
    run_op("xori",  32'h0F00C113, 32'hFF,      32'd0,       3'b011, 32'hF0,      3, 32'h0F,       2, 1'b1, 1'b0, 1'b0, 0);
    run_op("and_x0",32'h0020F033, 32'hF0F0,    32'hFF00,    3'b100, 32'hFF00,    3, 32'hF000,     0, 1'b0, 1'b0, 1'b0, 0);
    run_op("ori",   32'h8000E093, 32'd1,       32'd0,       3'b010, 32'hFFFFF800,3, 32'hFFFFF801, 1, 1'b1, 1'b0, 1'b0, 0);
    run_op("ill_f7",32'h022081B3, 32'd1,       32'd2,       3'b000, 32'd0,       1, 32'd0,        0, 1'b0, 1'b0, 1'b1, 0);

    // Reset while in EXEC: everything returns to reset values and the op never completes.
    @(posedge clk); #1;
    instr = 32'h002081B3; rs1_data = 32'd20; rs2_data = 32'd22; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst.in_ready", {31'b0, in_ready}, 32'd1);
    check("mid_rst.res_valid", {31'b0, res_valid}, 32'd0);
    check("mid_rst.data_1", data_1, 32'h0);
    check("mid_rst.data_2", data_2, 32'h0);
    check("mid_rst.code", {29'b0, ALU_Control_signal}, 32'h0);
    check("mid_rst.res_data", res_data, 32'h0);
    check("mid_rst.res_rd", {27'b0, res_rd}, 32'h0);
    check("mid_rst.ill", {31'b0, illegal}, 32'h0);
    #2;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("mid_rst.no_vld", {31'b0, res_valid}, 32'd0);
    end
    run_op("add2",  32'h002081B3, 32'd20,      32'd22,      3'b000, 32'd22,      3, 32'd42,       3, 1'b1, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
